// File: rtl/spi_regfile_pkg.sv
// Shared types for the SPI register-file peripheral: FSM states,
// R/W bit encoding and frame length derivation.
package spi_regfile_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_HOLD
   } state_e;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   function automatic int frame_w(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI pin, with rise/fall
// detection on the synchronized value.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
         s3_q <= RST_VAL;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign q_o    = s2_q;
   assign rise_o = s2_q & ~s3_q;
   assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 slave in front of a small register file.
// Define SPI_REGFILE_READBACK_EN to enable read frames on cipo.
module spi_regfile_peripheral
   import spi_regfile_pkg::*;
#(
   parameter int NUM_REGS = 5,
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sclk,
   input  logic                       ncs,
   input  logic                       copi,
   output logic                       cipo,
   output logic                       cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0] regs_flat,
   output logic                       wr_strobe,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic                       frame_err
);

   localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
   localparam int CNT_W   = $clog2(FRAME_W + 2);
   localparam logic [CNT_W-1:0]  CNT_ADDR = CNT_W'(1 + ADDR_W);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_W + 1);
   localparam logic [ADDR_W:0]   NREGS    = (ADDR_W + 1)'(NUM_REGS);

   logic unused_sclk_q, unused_copi_rise, unused_copi_fall;
   logic sclk_rise, sclk_fall;
   logic ncs_s, ncs_rise, ncs_fall;
   logic copi_s;

   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .d_i(sclk),
      .q_o(unused_sclk_q), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );
   spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
      .clk(clk), .rst(rst), .d_i(ncs),
      .q_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall)
   );
   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_copi (
      .clk(clk), .rst(rst), .d_i(copi),
      .q_o(copi_s), .rise_o(unused_copi_rise), .fall_o(unused_copi_fall)
   );

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [FRAME_W-1:0]   sh_q, sh_d;
   logic [1:0]           settle_q;
   logic                 armed_q;
   logic [DATA_W-1:0]    regs_q [NUM_REGS];
   logic                 wr_strobe_q, frame_err_q;
   logic [ADDR_W-1:0]    wr_addr_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      unique case (state_q)
         S_IDLE: begin
            if (ncs_fall && armed_q) begin
               state_d = S_ADDR;
               cnt_d   = '0;
               sh_d    = '0;
            end
         end
         default: begin
            if (ncs_rise) begin
               state_d = S_IDLE;
            end else if (sclk_rise) begin
               if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
               if (cnt_q < CNT_FULL) sh_d = {sh_q[FRAME_W-2:0], copi_s};
               if (state_q == S_ADDR && cnt_d == CNT_ADDR) state_d = S_DATA;
               if (state_q == S_DATA && cnt_d == CNT_FULL) state_d = S_HOLD;
            end
         end
      endcase
   end

   logic              f_rw, f_full, f_inrange, end_frame, do_wr, do_err;
   logic [ADDR_W-1:0] f_addr;
   logic [DATA_W-1:0] f_data;

   assign f_rw      = sh_q[FRAME_W-1];
   assign f_addr    = sh_q[DATA_W +: ADDR_W];
   assign f_data    = sh_q[DATA_W-1:0];
   assign f_full    = (cnt_q == CNT_FULL);
   assign f_inrange = ({1'b0, f_addr} < NREGS);
   assign end_frame = ncs_rise && (state_q != S_IDLE);
   assign do_wr     = end_frame && f_full && f_rw == RW_WRITE && f_inrange;
   assign do_err    = end_frame && (!f_full || (f_rw == RW_WRITE && !f_inrange));

   // Frames already in flight at reset release are ignored until ncs is seen high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         sh_q        <= '0;
         settle_q    <= '0;
         armed_q     <= 1'b0;
         wr_strobe_q <= 1'b0;
         frame_err_q <= 1'b0;
         wr_addr_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
         if (settle_q == 2'd3 && ncs_s) armed_q <= 1'b1;
         wr_strobe_q <= do_wr;
         frame_err_q <= do_err;
         if (do_wr) begin
            wr_addr_q <= f_addr;
            for (int i = 0; i < NUM_REGS; i++)
               if (f_addr == ADDR_W'(i)) regs_q[i] <= f_data;
         end
      end
   end

   always_comb begin
      regs_flat = '0;
      for (int i = 0; i < NUM_REGS; i++)
         regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
   end

   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign frame_err = frame_err_q;

`ifdef SPI_REGFILE_READBACK_EN
   logic [DATA_W-1:0] out_q, rd_val;
   logic              oe_q, skip_q, rd_load;

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (sh_d[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs_q[i];
   end

   assign rd_load = (state_q == S_ADDR) && (state_d == S_DATA) &&
                    (sh_d[ADDR_W] == RW_READ);

   // The fall right after the load belongs to the last address bit, so skip it.
   always_ff @(posedge clk) begin
      if (rst || state_d == S_IDLE) begin
         out_q  <= '0;
         oe_q   <= 1'b0;
         skip_q <= 1'b0;
      end else if (rd_load) begin
         out_q  <= rd_val;
         oe_q   <= 1'b1;
         skip_q <= 1'b1;
      end else if (oe_q && sclk_fall) begin
         if (skip_q) skip_q <= 1'b0;
         else        out_q  <= out_q << 1;
      end
   end

   assign cipo    = oe_q & out_q[DATA_W-1];
   assign cipo_oe = oe_q;
`else
   logic unused_sclk_fall;
   assign unused_sclk_fall = sclk_fall;
   assign cipo    = 1'b0;
   assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Self-checking bench for spi_regfile_peripheral: vector table, corner
// sequences and randomized frames against a register-array model.
module tb_spi_regfile_peripheral;

   localparam int NUM_REGS = 5;
   localparam int ADDR_W   = 7;
   localparam int DATA_W   = 8;
   localparam int FRAME_W  = 1 + ADDR_W + DATA_W;
   localparam int HB       = 4;

   logic clk = 1'b0;
   logic rst, sclk, ncs, copi;
   logic cipo, cipo_oe, wr_strobe, frame_err;
   logic [NUM_REGS*DATA_W-1:0] regs_flat;
   logic [ADDR_W-1:0] wr_addr;

   always #5 clk = ~clk;

   spi_regfile_peripheral #(
      .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
   ) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi),
      .cipo(cipo), .cipo_oe(cipo_oe), .regs_flat(regs_flat),
      .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
   );

   int tests = 0;
   int fails = 0;
   int n_strobe = 0;
   int n_err = 0;
   logic [ADDR_W-1:0] last_addr = '0;
   logic [DATA_W-1:0] model [NUM_REGS];

   always @(negedge clk) begin
      if (wr_strobe === 1'b1) begin
         n_strobe++;
         last_addr = wr_addr;
      end
      if (frame_err === 1'b1) n_err++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
      logic [NUM_REGS*DATA_W-1:0] f;
      for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = model[i];
      return f;
   endfunction

   function automatic bit exp_oe(input bit is_rd, input int i);
`ifdef SPI_REGFILE_READBACK_EN
      return is_rd && (i >= 1 + ADDR_W);
`else
      return 1'b0 & is_rd & (i > 0);
`endif
   endfunction

   task automatic shift_bits(input logic [FRAME_W-1:0] f, input int from, input int to,
                             input bit is_rd, inout logic [DATA_W-1:0] cap, inout int oe_bad);
      for (int i = from; i < to; i++) begin
         copi = (i < FRAME_W) ? f[FRAME_W-1-i] : 1'b0;
         tick(HB);
         if (cipo_oe !== exp_oe(is_rd, i)) oe_bad++;
         if (!exp_oe(is_rd, i) && cipo !== 1'b0) oe_bad++;
         if (i >= 1 + ADDR_W && i < FRAME_W) cap[FRAME_W-1-i] = cipo;
         sclk = 1'b1;
         tick(HB);
         sclk = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [FRAME_W-1:0] f, input int nbits,
                             output logic [DATA_W-1:0] cap, output int oe_bad);
      bit is_rd;
      is_rd  = (f[FRAME_W-1] == 1'b0);
      cap    = '0;
      oe_bad = 0;
      ncs = 1'b0;
      tick(HB);
      shift_bits(f, 0, nbits, is_rd, cap, oe_bad);
      tick(HB);
      ncs  = 1'b1;
      copi = 1'b0;
   endtask

   // Spec rules applied to one frame: update model, report expected events.
   task automatic model_frame(input logic [FRAME_W-1:0] f, input int nbits,
                              output int strobes, output int errs, output logic [DATA_W-1:0] rd);
      bit rw;
      int a;
      rw = f[FRAME_W-1];
      a  = int'(f[DATA_W +: ADDR_W]);
      rd = '0;
`ifdef SPI_REGFILE_READBACK_EN
      if (!rw && a < NUM_REGS) rd = model[a];
`endif
      strobes = 0;
      errs    = 0;
      if (nbits != FRAME_W || (rw && a >= NUM_REGS)) errs = 1;
      else if (rw) begin
         strobes  = 1;
         model[a] = f[DATA_W-1:0];
      end
   endtask

   typedef struct {
      logic [FRAME_W-1:0] frame;
      int                 nbits;
      int                 strobes;
      int                 errs;
   } vec_t;

   vec_t vecs [10];

   task automatic run_frame(input string tag, input logic [FRAME_W-1:0] f, input int nbits,
                            input bit use_exp, input int v_str, input int v_err);
      int s0, e0, oe_bad, m_str, m_err;
      logic [DATA_W-1:0] cap, exp_rd;
      s0 = n_strobe;
      e0 = n_err;
      model_frame(f, nbits, m_str, m_err, exp_rd);
      if (use_exp) begin
         m_str = v_str;
         m_err = v_err;
      end
      send_frame(f, nbits, cap, oe_bad);
      tick(10);
      check({tag, " strobes"}, 64'(n_strobe - s0), 64'(m_str));
      check({tag, " errs"}, 64'(n_err - e0), 64'(m_err));
      if (m_str == 1) check({tag, " wr_addr"}, 64'(last_addr), 64'(f[DATA_W +: ADDR_W]));
      check({tag, " regs"}, 64'(regs_flat), 64'(model_flat()));
      check({tag, " oe/cipo shape"}, 64'(oe_bad), 64'd0);
      if (f[FRAME_W-1] == 1'b0 && nbits >= FRAME_W)
         check({tag, " read data"}, 64'(cap), 64'(exp_rd));
      check({tag, " oe idle"}, 64'({cipo_oe, cipo}), 64'd0);
   endtask

   initial begin
      int oe_bad, s0, e0;
      logic [DATA_W-1:0] cap;

      vecs[0] = '{16'h82A5, 16, 1, 0};
      vecs[1] = '{16'h83C3, 15, 0, 1};
      vecs[2] = '{16'h873C, 16, 0, 1};
      vecs[3] = '{16'h845A, 16, 1, 0};
      vecs[4] = '{16'h0400, 16, 0, 0};
      vecs[5] = '{16'h0200,  9, 0, 1};
      vecs[6] = '{16'h8077, 17, 0, 1};
      vecs[7] = '{16'h8099, 16, 1, 0};
      vecs[8] = '{16'h7F00, 16, 0, 0};
      vecs[9] = '{16'h0200, 16, 0, 0};

      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      rst = 1'b1; sclk = 1'b0; ncs = 1'b1; copi = 1'b0;
      tick(4);
      check("reset regs", 64'(regs_flat), 64'd0);
      check("reset outs", 64'({wr_strobe, frame_err, cipo, cipo_oe, wr_addr}), 64'd0);
      rst = 1'b0;
      tick(8);

      for (int k = 0; k < 10; k++)
         run_frame($sformatf("vec%0d", k), vecs[k].frame, vecs[k].nbits,
                   1'b1, vecs[k].strobes, vecs[k].errs);

      // Reset in the middle of a write frame, then a clean write.
      s0 = n_strobe;
      e0 = n_err;
      cap = '0;
      oe_bad = 0;
      ncs = 1'b0;
      tick(HB);
      shift_bits(16'h81FF, 0, 10, 1'b0, cap, oe_bad);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      shift_bits(16'h81FF, 10, 16, 1'b0, cap, oe_bad);
      tick(HB);
      ncs = 1'b1;
      tick(10);
      check("abandon strobes", 64'(n_strobe - s0), 64'd0);
      check("abandon errs", 64'(n_err - e0), 64'd0);
      check("abandon regs", 64'(regs_flat), 64'd0);
      run_frame("post-reset write", 16'h8011, 16, 1'b0, 0, 0);

      // Back-to-back frames with a 2-clk ncs-high gap.
      s0 = n_strobe;
      e0 = n_err;
      send_frame(16'h8033, 16, cap, oe_bad);
      tick(2);
      send_frame(16'h8144, 16, cap, oe_bad);
      tick(10);
      model[0] = 8'h33;
      model[1] = 8'h44;
      check("b2b strobes", 64'(n_strobe - s0), 64'd2);
      check("b2b errs", 64'(n_err - e0), 64'd0);
      check("b2b regs", 64'(regs_flat), 64'(model_flat()));

      for (int k = 0; k < 30; k++) begin
         logic [FRAME_W-1:0] f;
         int nb, r;
         f = {1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom)};
         r = int'($urandom_range(0, 5));
         nb = (r == 0) ? 12 : (r == 1) ? 17 : 16;
         run_frame($sformatf("rand%0d", k), f, nb, 1'b0, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
